// File: rtl/fft_arith_pkg.sv
// Shared arithmetic definitions: divider FSM state encoding, default width and
// a counter-width helper.
package fft_arith_pkg;

   localparam int DIV_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2,
      ST_DONE   = 2'd3
   } div_state_e;

   function automatic int div_cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/divide_twos_mag.sv
// twos_mag: WIDTH-bit two's complement value to its WIDTH-bit unsigned magnitude.
// The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
module twos_mag
   import fft_arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] i_val,
   output logic [WIDTH-1:0] o_mag
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   assign o_mag = i_val[WIDTH-1] ? ((~i_val) + ONE) : i_val;

endmodule

// File: rtl/divide.sv
// divide: multi-cycle signed restoring divider, recomputes whenever the operand pair changes.
// Optional macro DIVIDE_DBZ_DETECT_EN adds the div_by_zero output and a one-edge zero-divisor path.
module divide
   import fft_arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clkin,
   input  logic             rstn_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             ready,
   output logic             sign,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
`ifdef DIVIDE_DBZ_DETECT_EN
   output logic             div_by_zero,
`endif
   output logic             overflow
);

   localparam int CW = div_cnt_width(WIDTH);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic             w_capture;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_qmag;
   logic [WIDTH-1:0] r_dmag;
   logic [WIDTH:0]   r_prem;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH+1:0] w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;
   logic             w_ovf_fin;
`ifdef DIVIDE_DBZ_DETECT_EN
   logic             w_dbz_fin;
`endif

   twos_mag #(.WIDTH(WIDTH)) u_dvd_mag (.i_val(dividend_in), .o_mag(w_dvd_mag));
   twos_mag #(.WIDTH(WIDTH)) u_dvs_mag (.i_val(divisor_in),  .o_mag(w_dvs_mag));

   assign sign      = dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
   assign w_capture = (r_state == ST_LOAD) || (dividend_in != r_dvd) || (divisor_in != r_dvs);

   // One restoring step: the remainder has a spare top bit so the compare never wraps.
   assign w_shift = {r_prem, r_qmag[WIDTH-1]};
   assign w_ge    = (w_shift >= {2'b00, r_dmag});

   // State register.
   always_ff @(posedge clkin or negedge rstn_in) begin
      if (!rstn_in) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: an operand change overrides whatever is in flight.
   always_comb begin
      w_state_nxt = r_state;
      if (w_capture) begin
`ifdef DIVIDE_DBZ_DETECT_EN
         if (divisor_in == ZERO) begin
            w_state_nxt = ST_FINISH;
         end else begin
            w_state_nxt = ST_RUN;
         end
`else
         w_state_nxt = ST_RUN;
`endif
      end else begin
         case (r_state)
            ST_RUN: begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_FINISH: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_LOAD;
         endcase
      end
   end

   // Sign fix-up and saturation applied to the magnitude result.
   always_comb begin
      w_q_fin   = r_qmag;
      w_r_fin   = r_prem[WIDTH-1:0];
      w_ovf_fin = 1'b0;
`ifdef DIVIDE_DBZ_DETECT_EN
      w_dbz_fin = 1'b0;
`endif
      if (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]) begin
         w_q_fin = (~r_qmag) + ONE;
      end else begin
         w_q_fin = r_qmag;
      end
      if (r_dvd[WIDTH-1]) begin
         w_r_fin = (~r_prem[WIDTH-1:0]) + ONE;
      end else begin
         w_r_fin = r_prem[WIDTH-1:0];
      end
      if ((r_dvd == MIN_NEG) && (r_dvs == ALL_ONES)) begin
         w_q_fin   = MAX_POS;
         w_ovf_fin = 1'b1;
      end else begin
         w_ovf_fin = 1'b0;
      end
`ifdef DIVIDE_DBZ_DETECT_EN
      if (r_dvs == ZERO) begin
         w_q_fin   = ZERO;
         w_r_fin   = r_dvd;
         w_dbz_fin = 1'b1;
      end else begin
         w_dbz_fin = 1'b0;
      end
`endif
   end

   // Operand capture, iteration datapath and registered results.
   always_ff @(posedge clkin or negedge rstn_in) begin
      if (!rstn_in) begin
         r_dvd     <= ZERO;
         r_dvs     <= ZERO;
         r_qmag    <= ZERO;
         r_dmag    <= ZERO;
         r_prem    <= '0;
         r_cnt     <= '0;
         ready     <= 1'b0;
         quotient  <= ZERO;
         remainder <= ZERO;
         overflow  <= 1'b0;
`ifdef DIVIDE_DBZ_DETECT_EN
         div_by_zero <= 1'b0;
`endif
      end else if (w_capture) begin
         r_dvd  <= dividend_in;
         r_dvs  <= divisor_in;
         r_qmag <= w_dvd_mag;
         r_dmag <= w_dvs_mag;
         r_prem <= '0;
         r_cnt  <= '0;
         ready  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_prem <= w_ge ? (w_shift[WIDTH:0] - {1'b0, r_dmag}) : w_shift[WIDTH:0];
               r_qmag <= {r_qmag[WIDTH-2:0], w_ge};
               r_cnt  <= r_cnt + CNT_ONE;
            end
            ST_FINISH: begin
               quotient  <= w_q_fin;
               remainder <= w_r_fin;
               overflow  <= w_ovf_fin;
               ready     <= 1'b1;
`ifdef DIVIDE_DBZ_DETECT_EN
               div_by_zero <= w_dbz_fin;
`endif
            end
            default: begin
               ready <= ready;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divide.sv
// tb_divide: directed literal checks plus randomized operand changes, compared every
// cycle against a latency-aware behavioural divider model.
module tb_divide;

   localparam int W = 8;

   logic         clkin       = 1'b0;
   logic         rstn_in     = 1'b0;
   logic [W-1:0] dividend_in = '0;
   logic [W-1:0] divisor_in  = '0;
   logic         ready;
   logic         sign;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         overflow;
`ifdef DIVIDE_DBZ_DETECT_EN
   logic         div_by_zero;
`endif

   int n_cmp  = 0;
   int n_bad  = 0;
   bit chk_en = 1'b0;

   divide #(.WIDTH(W)) dut (
      .clkin       (clkin),
      .rstn_in     (rstn_in),
      .dividend_in (dividend_in),
      .divisor_in  (divisor_in),
      .ready       (ready),
      .sign        (sign),
      .quotient    (quotient),
      .remainder   (remainder),
`ifdef DIVIDE_DBZ_DETECT_EN
      .div_by_zero (div_by_zero),
`endif
      .overflow    (overflow)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result from plain integer arithmetic.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic ovf, output logic dbz);
      int sa, sb, qi, ri;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      ovf = 1'b0;
      dbz = 1'b0;
      if (sb == 0) begin
`ifdef DIVIDE_DBZ_DETECT_EN
         qi  = 0;
         ri  = sa;
         dbz = 1'b1;
`else
         qi = (sa < 0) ? -((1 << W) - 1) : ((1 << W) - 1);
         ri = sa;
`endif
      end else if (sa == -(1 << (W - 1)) && sb == -1) begin
         qi  = (1 << (W - 1)) - 1;
         ri  = 0;
         ovf = 1'b1;
      end else begin
         qi = sa / sb;
         ri = sa % sb;
      end
      q = qi[W-1:0];
      r = ri[W-1:0];
   endfunction

   function automatic int lat_of(input logic [W-1:0] b);
`ifdef DIVIDE_DBZ_DETECT_EN
      if (b == '0) return 1;
`endif
      return W + 1;
   endfunction

   // Model: result appears a fixed number of edges after the last operand capture.
   bit           m_load  = 1'b1;
   bit           m_busy  = 1'b0;
   int           m_age   = 0;
   logic [W-1:0] m_a     = '0;
   logic [W-1:0] m_b     = '0;
   logic         m_ready = 1'b0;
   logic         m_ovf   = 1'b0;
   logic         m_dbz   = 1'b0;
   logic [W-1:0] m_q     = '0;
   logic [W-1:0] m_r     = '0;

   always @(posedge clkin or negedge rstn_in) begin
      if (!rstn_in) begin
         m_load = 1'b1; m_busy = 1'b0; m_age = 0; m_a = '0; m_b = '0;
         m_ready = 1'b0; m_ovf = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0;
      end else if (m_load || dividend_in != m_a || divisor_in != m_b) begin
         m_load  = 1'b0;
         m_a     = dividend_in;
         m_b     = divisor_in;
         m_age   = 0;
         m_busy  = 1'b1;
         m_ready = 1'b0;
      end else if (m_busy) begin
         m_age++;
         if (m_age == lat_of(m_b)) begin
            m_busy  = 1'b0;
            m_ready = 1'b1;
            ref_div(m_a, m_b, m_q, m_r, m_ovf, m_dbz);
         end
      end
   end

   always @(negedge clkin) begin
      if (chk_en) begin
         chk("cyc ready", ready, m_ready);
         chk("cyc quotient", quotient, m_q);
         chk("cyc remainder", remainder, m_r);
         chk("cyc overflow", overflow, m_ovf);
         chk("cyc sign", sign, dividend_in[W-1] ^ divisor_in[W-1]);
`ifdef DIVIDE_DBZ_DETECT_EN
         chk("cyc div_by_zero", div_by_zero, m_dbz);
`endif
      end
   end

   task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clkin);
      #2;
      dividend_in = a;
      divisor_in  = b;
   endtask

   // Waits through the latency window and pins the result to literal values.
   task automatic expect_result(input string nm, input logic [W-1:0] eq,
                                input logic [W-1:0] er, input logic eo);
      int l;
      l = lat_of(divisor_in);
      for (int k = 0; k < l; k++) begin
         @(posedge clkin);
         #1 chk({nm, " busy"}, ready, 1'b0);
      end
      @(posedge clkin);
      #1;
      chk({nm, " ready"}, ready, 1'b1);
      chk({nm, " quotient"}, quotient, eq);
      chk({nm, " remainder"}, remainder, er);
      chk({nm, " overflow"}, overflow, eo);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a, b;
      int sel;
      @(posedge clkin);
      #1;
      chk_en = 1'b1;
      chk("reset ready", ready, 1'b0);
      chk("reset quotient", quotient, 8'h00);
      chk("reset remainder", remainder, 8'h00);
      chk("reset overflow", overflow, 1'b0);
      repeat (2) @(posedge clkin);
      #3 rstn_in = 1'b1;

      apply(8'd100, 8'd7);
      expect_result("100/7", 8'd14, 8'd2, 1'b0);
      apply(8'h9C, 8'd7);
      expect_result("-100/7", 8'hF2, 8'hFE, 1'b0);
      apply(8'd7, 8'h9C);
      expect_result("7/-100", 8'h00, 8'h07, 1'b0);
      apply(8'h80, 8'hFF);
      expect_result("-128/-1", 8'h7F, 8'h00, 1'b1);

      apply(8'd100, 8'd7);
      repeat (3) @(posedge clkin);
      apply(8'd50, 8'd5);
      expect_result("50/5 restart", 8'd10, 8'd0, 1'b0);

`ifdef DIVIDE_DBZ_DETECT_EN
      apply(8'h55, 8'h00);
      expect_result("0x55/0", 8'h00, 8'h55, 1'b0);
      chk("0x55/0 div_by_zero", div_by_zero, 1'b1);
`else
      apply(8'h55, 8'h00);
      expect_result("0x55/0", 8'hFF, 8'h55, 1'b0);
`endif

      apply(8'hB3, 8'd9);
      repeat (3) @(posedge clkin);
      #3 rstn_in = 1'b0;
      #1;
      chk("async rst ready", ready, 1'b0);
      chk("async rst quotient", quotient, 8'h00);
      chk("async rst remainder", remainder, 8'h00);
      chk("async rst overflow", overflow, 1'b0);
      @(posedge clkin);
      #3 rstn_in = 1'b1;
      expect_result("-77/9 after rst", 8'hF8, 8'hFB, 1'b0);

      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         a   = W'($urandom);
         b   = W'($urandom);
         case (sel)
            0: apply(a, 8'h00);
            1: apply(8'h80, 8'hFF);
            2: apply(dividend_in, divisor_in);
            3: begin
               @(posedge clkin);
               #3 rstn_in = 1'b0;
               @(posedge clkin);
               #3 rstn_in = 1'b1;
            end
            default: apply(a, b);
         endcase
         repeat ($urandom_range(1, 14)) @(posedge clkin);
      end
      repeat (12) @(posedge clkin);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits, two's complement, WIDTH >= 4.
REQ-002 clkin  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn_in  input  1  asynchronous, active-low reset.
REQ-004 dividend_in  input  WIDTH  signed dividend.
REQ-005 divisor_in  input  WIDTH  signed divisor.
REQ-006 ready  output  1  registered; high when quotient/remainder reflect the currently captured operands.
REQ-007 sign  output  1  combinational, dividend_in[WIDTH-1] XOR divisor_in[WIDTH-1].
REQ-008 quotient  output  WIDTH  registered signed quotient, truncated toward zero.
REQ-009 remainder  output  WIDTH  registered signed remainder; sign follows dividend; zero remainder is 0.
REQ-010 overflow  output  1  registered; high only for result of -2^(WIDTH-1) / -1.

Function
REQ-011 The block shall use states LOAD, RUN, FINISH, DONE.
REQ-012 At any edge where (dividend_in, divisor_in) differs from the captured pair, or state is LOAD, the block shall capture both operands, store magnitudes as WIDTH-bit unsigned, clear the partial remainder and counter, drive ready 0, and enter RUN.
REQ-013 A capture per REQ-012 shall take priority over every other transition, including mid-RUN and FINISH; the in-flight result shall be discarded.
REQ-014 RUN shall perform one restoring-division step per edge: shift {partial remainder, dividend magnitude} left 1; if partial remainder >= divisor magnitude, subtract and set quotient bit 1.
REQ-015 RUN shall last exactly WIDTH edges, then enter FINISH.
REQ-016 FINISH shall apply signs (quotient negated when captured signs differ, remainder negated when captured dividend negative), update quotient/remainder/overflow, set ready 1, and enter DONE.
REQ-017 Latency: ready shall rise at capture edge + WIDTH + 1 edges (9 for WIDTH=8).
REQ-018 DONE shall hold outputs and ready 1 until the next capture.
REQ-019 Outputs quotient/remainder/overflow shall change only in FINISH or reset; during RUN they shall hold the previous result.
REQ-020 For -2^(WIDTH-1) / -1 the quotient shall saturate to 2^(WIDTH-1)-1 and overflow shall be 1; otherwise overflow 0.
REQ-021 Partial remainder width shall be WIDTH+1 bits so the compare never wraps.

Reset
REQ-022 Reset assertion shall immediately force ready 0, quotient 0, remainder 0, overflow 0, captured operands 0, counter 0, state LOAD.
REQ-023 Reset mid-RUN shall abandon the operation; the first edge after release shall capture current inputs.

Configuration
REQ-024 Macro DIVIDE_DBZ_DETECT_EN: when defined, output div_by_zero (1 bit, registered, reset 0) shall exist; a captured divisor of 0 shall skip RUN, and the next edge shall set quotient 0, remainder = dividend, div_by_zero 1, ready 1.
REQ-025 When DIVIDE_DBZ_DETECT_EN is undefined, port div_by_zero shall be absent and divisor 0 shall run the normal WIDTH-step algorithm (magnitude quotient all ones, remainder = dividend magnitude, signs per REQ-016).

Structure
REQ-026 State encodings and default WIDTH shall live in shared package fft_arith_pkg.
REQ-027 One sub-module, twos_mag (WIDTH-bit signed value to unsigned magnitude), shall be instantiated for each operand.

Verification
REQ-028 WIDTH=8, reset release, apply 100 / 7 -> 9 edges after capture: ready 1, quotient 14, remainder 2, overflow 0.
REQ-029 -100 / 7 -> quotient 0xF2 (-14), remainder 0xFE (-2); 7 / -100 -> quotient 0, remainder 7.
REQ-030 -128 / -1 -> quotient 0x7F, remainder 0, overflow 1.
REQ-031 Apply 100 / 7, change to 50 / 5 four edges later -> ready stays 0, then quotient 10, remainder 0 nine edges after second capture.
REQ-032 With DIVIDE_DBZ_DETECT_EN: 0x55 / 0 -> one edge after capture: ready 1, quotient 0, remainder 0x55, div_by_zero 1; without it: quotient 0xFF, remainder 0x55 after 9 edges.
REQ-033 Assert rstn_in mid-RUN -> all outputs 0 asynchronously; after release, current operands computed with REQ-017 latency.
